wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback (MEM/WB outputs) and one long-latency auxiliary result source, such as the multi-cycle divider or a load-refill return.
- Auxiliary results queue in a 2-entry FIFO. The pipeline has priority.
- A starvation counter forces a one-cycle pipeline stall request so that queued auxiliary results always drain.
- Sits between MEM/WB and regfile; stall_req feeds the pipeline ctrl block.

---
 rtl/wb_port_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over a
// 2-entry auxiliary result FIFO, with a starvation counter that forces a drain.
module wb_port_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_waddr,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          aux_valid,
  output logic          aux_ready,
  input  logic [AW-1:0] aux_waddr,
  input  logic [DW-1:0] aux_wdata,
  output logic          stall_req,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  logic [AW-1:0] fifo_addr_q [2];
  logic [DW-1:0] fifo_data_q [2];

  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          stall_req_q, stall_req_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;

  logic          push;
  logic          fifo_nonempty;
  logic          grant_fifo;
  logic          grant_pipe;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  // Acceptance depends only on the current occupancy, so a full FIFO refuses
  // a push even in a cycle where it pops.
  assign aux_ready     = !rst && (count_q < 2'd2);
  assign push          = aux_valid && aux_ready;
  assign fifo_nonempty = (count_q != 2'd0);
  assign head_addr     = fifo_addr_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];

  // During a forced stall the pipe inputs are frozen by ctrl and must be ignored.
  assign grant_pipe = !stall_req_q && pipe_we;
  assign grant_fifo = fifo_nonempty && (stall_req_q || !pipe_we);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    starve_cnt_d = 4'd0;
    stall_req_d  = 1'b0;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;

    if (push) begin
      wr_ptr_d = !wr_ptr_q;
    end
    if (grant_fifo) begin
      rd_ptr_d = !rd_ptr_q;
    end

    unique case ({push, grant_fifo})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // The head losing at the last allowed count requests a one-cycle stall;
    // the stall cycle always grants the head, so stalls never run back-to-back.
    if (fifo_nonempty && !grant_fifo) begin
      starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
      stall_req_d  = (starve_cnt_q == STARVE_LAST);
    end

    if (grant_pipe) begin
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
      rf_we_d    = (pipe_waddr != '0);
    end else if (grant_fifo) begin
      rf_waddr_d = head_addr;
      rf_wdata_d = head_data;
      rf_we_d    = (head_addr != '0);
    end
  end

  // NOTE: FIFO storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= aux_waddr;
      fifo_data_q[wr_ptr_q] <= aux_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      starve_cnt_q <= 4'd0;
      stall_req_q  <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      stall_req_q  <= stall_req_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign stall_req = stall_req_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs change on the falling edge and
// outputs are sampled there, half a cycle after each rising edge.
module tb_wb_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          aux_valid;
  logic          aux_ready;
  logic [AW-1:0] aux_waddr;
  logic [DW-1:0] aux_wdata;
  logic          stall_req;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .aux_valid  (aux_valid),
    .aux_ready  (aux_ready),
    .aux_waddr  (aux_waddr),
    .aux_wdata  (aux_wdata),
    .stall_req  (stall_req),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_pipe(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pipe_we    = we;
    pipe_waddr = a;
    pipe_wdata = d;
  endtask

  task automatic set_aux(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    aux_valid = v;
    aux_waddr = a;
    aux_wdata = d;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    check({tag, "_we"},   32'(rf_we),    32'(we));
    check({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    check({tag, "_data"}, rf_wdata,      d);
  endtask

  initial begin
    // Reset held two cycles with both sources active: nothing may be accepted.
    rst = 1'b1;
    set_pipe(1'b1, 5'd5, 32'h0000_0001);
    set_aux(1'b1, 5'd6, 32'h0000_0066);
    tick();
    tick();
    check("rst_aux_ready", 32'(aux_ready), 32'd0);
    check("rst_stall",     32'(stall_req), 32'd0);
    check_rf("rst", 1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    set_pipe(1'b0, 5'd0, 32'd0);
    set_aux(1'b0, 5'd0, 32'd0);
    #1;
    check("post_rst_ready", 32'(aux_ready), 32'd1);
    tick();
    check("rst_no_push", 32'(rf_we), 32'd0);

    // Pipe-only write: one cycle latency, then address/data hold when idle.
    set_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    check_rf("pipe", 1'b1, 5'd5, 32'hDEAD_BEEF);
    set_pipe(1'b0, 5'd0, 32'd0);
    tick();
    check_rf("pipe_hold", 1'b0, 5'd5, 32'hDEAD_BEEF);

    // Aux on an idle port: push edge, head cycle, output edge.
    set_aux(1'b1, 5'd7, 32'h1234_5678);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    check("aux_head_cycle_we", 32'(rf_we), 32'd0);
    tick();
    check_rf("aux_idle", 1'b1, 5'd7, 32'h1234_5678);
    tick();
    check("aux_drained_we", 32'(rf_we), 32'd0);

    // Dedicated starvation: one entry, pipe writing every cycle.
    set_pipe(1'b1, 5'd4, 32'h0000_0044);
    set_aux(1'b1, 5'd10, 32'hA5A5_A5A5);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("starve_wait%0d", i), 32'(stall_req), 32'd0);
      check_rf($sformatf("starve_pipe%0d", i), 1'b1, 5'd4, 32'h0000_0044);
      tick();
    end
    check("starve_stall", 32'(stall_req), 32'd1);
    set_pipe(1'b1, 5'd3, 32'h0000_0033);
    tick();
    check_rf("starve_grant", 1'b1, 5'd10, 32'hA5A5_A5A5);
    check("starve_stall_drop", 32'(stall_req), 32'd0);
    tick();
    check_rf("starve_pipe_r3", 1'b1, 5'd3, 32'h0000_0033);
    check("starve_no_repeat", 32'(stall_req), 32'd0);

    // Full FIFO under continuous pipe traffic, third push held off until a pop.
    set_pipe(1'b1, 5'd1, 32'h0000_0011);
    set_aux(1'b1, 5'd8, 32'h0000_0088);
    tick();
    check("full_ready_after1", 32'(aux_ready), 32'd1);
    set_aux(1'b1, 5'd9, 32'h0000_0099);
    tick();
    check("full_ready_after2", 32'(aux_ready), 32'd0);
    set_aux(1'b1, 5'd11, 32'h0000_00BB);
    set_pipe(1'b1, 5'd2, 32'h0000_0022);
    tick();
    check("full_refuse", 32'(aux_ready), 32'd0);
    check_rf("full_pipe", 1'b1, 5'd2, 32'h0000_0022);
    tick();
    check("full_stall_c3", 32'(stall_req), 32'd0);
    tick();
    check("full_stall", 32'(stall_req), 32'd1);
    check("full_stall_ready", 32'(aux_ready), 32'd0);
    set_pipe(1'b1, 5'd3, 32'h0000_0033);
    tick();
    check_rf("full_head_r8", 1'b1, 5'd8, 32'h0000_0088);
    check("full_ready_after_pop", 32'(aux_ready), 32'd1);
    tick();
    check_rf("full_pipe_r3", 1'b1, 5'd3, 32'h0000_0033);
    check("full_third_taken", 32'(aux_ready), 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    set_aux(1'b0, 5'd0, 32'd0);
    tick();
    check_rf("full_drain_r9", 1'b1, 5'd9, 32'h0000_0099);
    tick();
    check_rf("full_drain_r11", 1'b1, 5'd11, 32'h0000_00BB);
    tick();
    check("full_empty_we", 32'(rf_we), 32'd0);

    // Writes to r0 are discarded but still consume the grant and the pop.
    set_pipe(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    check_rf("r0_pipe", 1'b0, 5'd0, 32'hFFFF_FFFF);
    set_pipe(1'b0, 5'd0, 32'd0);
    set_aux(1'b1, 5'd0, 32'h0000_CAFE);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    tick();
    check_rf("r0_aux", 1'b0, 5'd0, 32'h0000_CAFE);
    set_pipe(1'b1, 5'd12, 32'h0000_00CC);
    set_aux(1'b1, 5'd13, 32'h0000_00DD);
    tick();
    check("r0_popped_ready", 32'(aux_ready), 32'd1);
    set_pipe(1'b0, 5'd0, 32'd0);
    set_aux(1'b0, 5'd0, 32'd0);
    tick();
    check_rf("r0_next_entry", 1'b1, 5'd13, 32'h0000_00DD);

    // Reset mid-operation discards a queued entry.
    set_pipe(1'b1, 5'd14, 32'h0000_00EE);
    set_aux(1'b1, 5'd15, 32'h0000_00FF);
    tick();
    set_aux(1'b0, 5'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(aux_ready), 32'd0);
    tick();
    rst = 1'b0;
    check_rf("midrst", 1'b0, 5'd0, 32'd0);
    tick();
    check("midrst_discard", 32'(rf_we), 32'd0);
    tick();
    check("midrst_still_idle", 32'(rf_we), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
